cc_rd_fill_requester: RTL and testbench
=======================================

# cc_rd_fill_requester

Command initiator for the `CC_RD_FILL` (code 8) transaction. It sends the two-word command packet (CSN, CC) on an outgoing AXI-Stream, then parses the response packet from the fill responder on an incoming AXI-Stream. It validates RSN/RC, captures the 128-bit fill header and forwards ADC data words downstream. It sits on the controller side of the Aurora link, opposite the per-channel fill read-out state machine.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle-cycle limit on the RX stream while a response is outstanding; 0 disables the watchdog.
- `clk`  in  1  local clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that starts a transaction; ignored while `busy`.
- `csn`  in  32  command serial number, latched on `start`.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at transaction end.
- `tx_tdata`  out  32  command word.
- `tx_tvalid`  out  1  command word valid.
- `tx_tlast`  out  1  asserted with the CC word.
- `tx_tready`  in  1  TX FIFO accepts the word.
- `rx_tdata`  in  32  response word.
- `rx_tvalid`  in  1  response word valid.
- `rx_tlast`  in  1  last word of the response.
- `rx_tready`  out  1  requester accepts the response word.
- `fill_header`  out  128  captured header; word 0 in bits [31:0].
- `header_valid`  out  1  one-cycle pulse when all 4 header words are captured.
- `data_tdata`  out  32  ADC data word.
- `data_tvalid`  out  1  ADC data valid.
- `data_tready`  in  1  downstream accepts ADC data.
- `err_rsn`, `err_no_fill`, `err_length`, `err_checksum`, `err_timeout`  out  1 each  sticky status flags; cleared on `start`.
- `words_rcvd`  out  23  count of ADC data words accepted in the current transaction.

## Operation
- States: IDLE, SEND_CSN, SEND_CC, RX_RSN, RX_RC, RX_HDR, RX_DATA, RX_CKSUM, DRAIN, DONE.
- IDLE: on `start`, latch `csn`, clear all err flags and `words_rcvd`, go to SEND_CSN.
- SEND_CSN: drive `tx_tdata`=csn with `tx_tvalid`=1. On handshake, go to SEND_CC.
- SEND_CC: drive `tx_tdata`=32'h0000_0008 with `tx_tvalid`=1 and `tx_tlast`=1. On handshake, go to RX_RSN.
- RX_RSN: if the word ≠ latched csn, set `err_rsn` and go to DRAIN (or DONE if `rx_tlast`). Otherwise go to RX_RC.
- RX_RC:
  - Word 32'h0000_0008 → RX_HDR.
  - Word 32'hFFFF_FFF7 → set `err_no_fill` and go to DONE if `rx_tlast`, else set `err_length` and go to DRAIN.
  - Any other word → set `err_rsn` and go to DRAIN.
  - `rx_tlast` together with 32'h8 → set `err_length` and go to DONE.
- RX_HDR: capture 4 words, header word index 0..3. After the 4th word:
  - pulse `header_valid`;
  - load `expected` = {fill_header[84:64]+21'd2, 2'b00}, computed in 23 bits, so that 21-bit wrap after +2 is preserved exactly;
  - go to RX_DATA, or to RX_CKSUM if `expected`=0.
  - `rx_tlast` on any header word → `err_length`, then DONE.
- RX_DATA:
  - `rx_tready` = `data_tready`, combinationally; `data_tvalid` = `rx_tvalid`; `data_tdata` = `rx_tdata`.
  - Each handshake increments `words_rcvd` and adds the word to a 32-bit modular sum.
  - When `words_rcvd` reaches `expected`, go to RX_CKSUM.
  - `rx_tlast` on a data word → `err_length`, then DONE.
- RX_CKSUM: accept one word.
  - If it differs from the sum, set `err_checksum`.
  - If `rx_tlast`=1, go to DONE; otherwise set `err_length` and go to DRAIN.
- DRAIN: `rx_tready`=1 and discard words until a word with `rx_tlast` is accepted, then go to DONE.
- DONE: pulse `done`, return to IDLE. `busy` = (state ≠ IDLE).
- Watchdog: in RX_* and DRAIN, count cycles with no `rx_tvalid`, reset on each RX handshake. On reaching `TIMEOUT_CYCLES`, set `err_timeout` and go to DONE.
- RX words arriving in IDLE are not accepted: `rx_tready`=0.

## Timing
- Reset values: all outputs 0, `fill_header`=0, state IDLE.
- Reset mid-transaction aborts immediately with no `done` pulse.
- `tx_*` and `header_valid`/`done` are registered. `rx_tready` is combinational from state and `data_tready` only; it never depends on `rx_tvalid`.
- `start` → `tx_tvalid` 1 cycle later.
- With `tx_tready` held high, CSN and CC go out on consecutive cycles.
- RX accepts 1 word/cycle in every RX state. The data path adds zero latency.
- `done` asserts 1 cycle after the final accepted word. Err flags are valid when `done` is high.

## Configuration
- `CC_RD_FILL_CKSUM_CHECK_EN` defined: the sum is accumulated and compared, and `err_checksum` is set on mismatch.
- Undefined: the accumulator is removed, the checksum word is consumed and discarded, and `err_checksum` is tied to 0.

## Test plan
- Normal fill: csn=0x1234, header[84:64]=1 → expected=12; RX sends RSN 0x1234, RC 0x8, 4 header words, data 1..12, checksum 78 with tlast. Require `words_rcvd`=12, no errors, `done` pulse, `header_valid` one cycle.
- No fill: RX sends 0x1234, then 0xFFFFFFF7 with tlast. Require `err_no_fill`=1, `done`, no `header_valid`.
- Bad RSN: RX sends 0x1235, then 5 words ending with tlast. Require `err_rsn`=1 and all 6 words drained before `done`.
- Short packet: `expected`=12, but tlast arrives on data word 7. Require `err_length`=1 and `words_rcvd`=7.
- Backpressure: toggle `data_tready` randomly during 12 data words. Require no word lost or duplicated, and `rx_tready` follows `data_tready`. With the macro defined, a checksum of 77 sets `err_checksum`.
- Timeout: `TIMEOUT_CYCLES`=100, RX silent after RC. Require `err_timeout` at cycle 100 and `done`; `reset_n` low mid-transfer returns all outputs to 0.

Source files
------------

// File: rtl/cc_rd_fill_requester.sv
// CC_RD_FILL (code 8) command initiator: sends CSN/CC, then validates and unpacks the fill response.
// Optional build macro: CC_RD_FILL_CKSUM_CHECK_EN enables the data checksum accumulator and compare.
module cc_rd_fill_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [31:0]  csn,
  output logic         busy,
  output logic         done,
  output logic [31:0]  tx_tdata,
  output logic         tx_tvalid,
  output logic         tx_tlast,
  input  logic         tx_tready,
  input  logic [31:0]  rx_tdata,
  input  logic         rx_tvalid,
  input  logic         rx_tlast,
  output logic         rx_tready,
  output logic [127:0] fill_header,
  output logic         header_valid,
  output logic [31:0]  data_tdata,
  output logic         data_tvalid,
  input  logic         data_tready,
  output logic         err_rsn,
  output logic         err_no_fill,
  output logic         err_length,
  output logic         err_checksum,
  output logic         err_timeout,
  output logic [22:0]  words_rcvd
);

  localparam logic [31:0] CC_CODE  = 32'h0000_0008;
  localparam logic [31:0] NO_FILL  = 32'hFFFF_FFF7;
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYCLES) - 32'd1;

  typedef enum logic [3:0] {
    IDLE, SEND_CSN, SEND_CC, RX_RSN, RX_RC, RX_HDR, RX_DATA, RX_CKSUM, DRAIN, DONE
  } state_t;

  state_t      state, state_nx;
  logic [31:0] csn_q;
  logic [1:0]  hdr_idx;
  logic [22:0] expected;
  logic [22:0] expected_nx;
  logic [20:0] len_p2;
  logic [31:0] wd_cnt;
  logic        rx_phase, rx_hs, tx_hs, timeout_hit, hdr_done;
  logic        set_rsn, set_no_fill, set_len, set_to;

  // Length field plus two, wrapped in 21 bits, then scaled to 32-bit words.
  assign len_p2      = fill_header[84:64] + 21'd2;
  assign expected_nx = {len_p2, 2'b00};

  assign busy        = (state != IDLE);
  assign rx_phase    = state inside {RX_RSN, RX_RC, RX_HDR, RX_DATA, RX_CKSUM, DRAIN};
  assign rx_tready   = (state == RX_DATA) ? data_tready : (rx_phase ? 1'b1 : 1'b0);
  assign rx_hs       = rx_tvalid & rx_tready;
  assign tx_hs       = tx_tvalid & tx_tready;
  assign data_tvalid = (state == RX_DATA) & rx_tvalid;
  assign data_tdata  = (state == RX_DATA) ? rx_tdata : 32'h0;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && rx_phase && !rx_tvalid && (wd_cnt == WD_LAST);

`ifdef CC_RD_FILL_CKSUM_CHECK_EN
  logic [31:0] sum;
  logic        set_ck;
`else
  assign err_checksum = 1'b0;
`endif

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nx    = state;
    set_rsn     = 1'b0;
    set_no_fill = 1'b0;
    set_len     = 1'b0;
    set_to      = 1'b0;
    hdr_done    = 1'b0;
`ifdef CC_RD_FILL_CKSUM_CHECK_EN
    set_ck      = 1'b0;
`endif
    case (state)
      IDLE:     if (start) state_nx = SEND_CSN;
      SEND_CSN: if (tx_hs) state_nx = SEND_CC;
      SEND_CC:  if (tx_hs) state_nx = RX_RSN;
      RX_RSN: if (rx_hs) begin
        if (rx_tdata != csn_q) begin
          set_rsn  = 1'b1;
          state_nx = rx_tlast ? DONE : DRAIN;
        end else if (rx_tlast) begin
          set_len  = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = RX_RC;
        end
      end
      RX_RC: if (rx_hs) begin
        if (rx_tdata == CC_CODE) begin
          set_len  = rx_tlast;
          state_nx = rx_tlast ? DONE : RX_HDR;
        end else if (rx_tdata == NO_FILL) begin
          set_no_fill = 1'b1;
          set_len     = !rx_tlast;
          state_nx    = rx_tlast ? DONE : DRAIN;
        end else begin
          set_rsn  = 1'b1;
          state_nx = rx_tlast ? DONE : DRAIN;
        end
      end
      RX_HDR: if (rx_hs) begin
        if (rx_tlast) begin
          set_len  = 1'b1;
          state_nx = DONE;
        end else if (hdr_idx == 2'd3) begin
          hdr_done = 1'b1;
          state_nx = (expected_nx == 23'd0) ? RX_CKSUM : RX_DATA;
        end
      end
      RX_DATA: if (rx_hs) begin
        if (rx_tlast) begin
          set_len  = 1'b1;
          state_nx = DONE;
        end else if (words_rcvd + 23'd1 == expected) begin
          state_nx = RX_CKSUM;
        end
      end
      RX_CKSUM: if (rx_hs) begin
`ifdef CC_RD_FILL_CKSUM_CHECK_EN
        set_ck   = (rx_tdata != sum);
`endif
        set_len  = !rx_tlast;
        state_nx = rx_tlast ? DONE : DRAIN;
      end
      DRAIN:   if (rx_hs && rx_tlast) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (timeout_hit) begin
      set_to   = 1'b1;
      state_nx = DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done         <= 1'b0;
      header_valid <= 1'b0;
      tx_tvalid    <= 1'b0;
      tx_tlast     <= 1'b0;
      tx_tdata     <= 32'h0;
      csn_q        <= 32'h0;
      fill_header  <= 128'h0;
      hdr_idx      <= 2'd0;
      expected     <= 23'd0;
      words_rcvd   <= 23'd0;
      wd_cnt       <= 32'd0;
      err_rsn      <= 1'b0;
      err_no_fill  <= 1'b0;
      err_length   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      done         <= (state_nx == DONE);
      header_valid <= hdr_done;
      tx_tvalid    <= (state_nx == SEND_CSN) || (state_nx == SEND_CC);
      tx_tlast     <= (state_nx == SEND_CC);
      if (state_nx == SEND_CC)       tx_tdata <= CC_CODE;
      else if (state_nx == SEND_CSN) tx_tdata <= (state == IDLE) ? csn : csn_q;
      else                           tx_tdata <= 32'h0;

      if (!rx_phase || rx_hs) wd_cnt <= 32'd0;
      else if (!rx_tvalid)    wd_cnt <= wd_cnt + 32'd1;

      if (state == IDLE && start) begin
        csn_q       <= csn;
        hdr_idx     <= 2'd0;
        words_rcvd  <= 23'd0;
        err_rsn     <= 1'b0;
        err_no_fill <= 1'b0;
        err_length  <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (set_rsn)     err_rsn     <= 1'b1;
        if (set_no_fill) err_no_fill <= 1'b1;
        if (set_len)     err_length  <= 1'b1;
        if (set_to)      err_timeout <= 1'b1;
        if (state == RX_HDR && rx_hs) begin
          fill_header[{hdr_idx, 5'd0} +: 32] <= rx_tdata;
          hdr_idx <= hdr_idx + 2'd1;
        end
        if (hdr_done) expected <= expected_nx;
        if (state == RX_DATA && rx_hs) words_rcvd <= words_rcvd + 23'd1;
      end
    end
  end

`ifdef CC_RD_FILL_CKSUM_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum          <= 32'h0;
      err_checksum <= 1'b0;
    end else if (state == IDLE && start) begin
      sum          <= 32'h0;
      err_checksum <= 1'b0;
    end else begin
      if (state == RX_DATA && rx_hs) sum <= sum + rx_tdata;
      if (set_ck) err_checksum <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cc_rd_fill_requester.sv
// Scoreboard bench for cc_rd_fill_requester: directed response packets, decoupled output monitor.
module tb_cc_rd_fill_requester;

  logic         clk = 1'b0;
  logic         reset_n, start, tx_tready, rx_tvalid, rx_tlast, data_tready;
  logic [31:0]  csn, rx_tdata;
  logic         busy, done, tx_tvalid, tx_tlast, rx_tready, header_valid, data_tvalid;
  logic [31:0]  tx_tdata, data_tdata;
  logic [127:0] fill_header;
  logic         err_rsn, err_no_fill, err_length, err_checksum, err_timeout;
  logic [22:0]  words_rcvd;

`ifdef CC_RD_FILL_CKSUM_CHECK_EN
  localparam logic CK_EN = 1'b1;
`else
  localparam logic CK_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rsn, no_fill, len, ck, to;
    logic [22:0] words;
  } res_t;

  int           total = 0;
  int           bad   = 0;
  int           done_cnt = 0;
  int           hv_cnt   = 0;
  logic         bp_en = 1'b0;
  logic [32:0]  exp_tx[$];
  logic [31:0]  exp_data[$];
  logic [127:0] exp_hdr[$];
  res_t         exp_res[$];
  logic [31:0]  rxq[$];

  cc_rd_fill_requester #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .csn(csn), .busy(busy), .done(done),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
    .fill_header(fill_header), .header_valid(header_valid),
    .data_tdata(data_tdata), .data_tvalid(data_tvalid), .data_tready(data_tready),
    .err_rsn(err_rsn), .err_no_fill(err_no_fill), .err_length(err_length),
    .err_checksum(err_checksum), .err_timeout(err_timeout), .words_rcvd(words_rcvd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic res_t mk_res(input logic rsn, nf, len, ck, to, input logic [22:0] w);
    mk_res = '{rsn: rsn, no_fill: nf, len: len, ck: ck, to: to, words: w};
  endfunction

  // Monitor: compares every DUT presentation against the head of the matching queue.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (tx_tvalid && tx_tready) begin
        check("tx_expected", 128'(exp_tx.size() != 0), 128'(1));
        if (exp_tx.size() != 0) check("tx_word", 128'({tx_tlast, tx_tdata}), 128'(exp_tx.pop_front()));
      end
      if (data_tvalid) check("rx_follow", 128'(rx_tready), 128'(data_tready));
      if (data_tvalid && data_tready) begin
        check("data_expected", 128'(exp_data.size() != 0), 128'(1));
        if (exp_data.size() != 0) check("data_word", 128'(data_tdata), 128'(exp_data.pop_front()));
      end
      if (header_valid) begin
        hv_cnt++;
        check("hdr_expected", 128'(exp_hdr.size() != 0), 128'(1));
        if (exp_hdr.size() != 0) check("fill_header", fill_header, exp_hdr.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("res_expected", 128'(exp_res.size() != 0), 128'(1));
        if (exp_res.size() != 0)
          check("result", 128'({err_rsn, err_no_fill, err_length, err_checksum, err_timeout, words_rcvd}),
                128'(exp_res.pop_front()));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) data_tready = 1'($urandom_range(0, 1));
  end

  task automatic start_txn(input logic [31:0] c);
    @(posedge clk); #1;
    start = 1'b1;
    csn   = c;
    exp_tx.push_back({1'b0, c});
    exp_tx.push_back({1'b1, 32'h8});
    @(posedge clk); #1;
    start = 1'b0;
    check("tx_valid_lat", 128'(tx_tvalid), 128'(1));
  endtask

  // Sends rxq one word per accepted handshake; tlast on the final word when with_last is set.
  task automatic send_rx(input logic with_last, output int acc);
    logic r;
    int   spins;
    acc = 0;
    for (int i = 0; i < rxq.size(); i++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = rxq[i];
      rx_tlast  = with_last && (i == rxq.size() - 1);
      spins = 0;
      do begin
        @(negedge clk);
        r = rx_tready;
        @(posedge clk);
        spins++;
      end while (!r && spins < 300);
      #1;
      if (!r) begin
        check("rx_accept_wait", 128'(r), 128'(1));
        break;
      end
      acc++;
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tdata  = 32'h0;
    rxq.delete();
  endtask

  task automatic finish_txn(input int d0, input int hv0, input int hv_exp);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 128'(done_cnt), 128'(d0 + 1));
    repeat (2) @(posedge clk);
    #1;
    check("hv_count", 128'(hv_cnt - hv0), 128'(hv_exp));
    check("busy_end", 128'(busy), 128'(0));
    check("pend_queues", 128'(exp_tx.size() + exp_data.size() + exp_hdr.size() + exp_res.size()), 128'(0));
  endtask

  task automatic push_hdr(input logic [31:0] c, input logic [31:0] w2);
    rxq = '{c, 32'h8, 32'h1111_1111, 32'h2222_2222, w2, 32'h4444_4444};
    exp_hdr.push_back({32'h4444_4444, w2, 32'h2222_2222, 32'h1111_1111});
  endtask

  initial begin
    int d0, hv0, acc, n;
    reset_n = 1'b0; start = 1'b0; csn = 32'h0; tx_tready = 1'b1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = 32'h0; data_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 128'({busy, done, tx_tvalid, tx_tlast, rx_tready, header_valid, data_tvalid}), 128'(0));
    check("rst_status", 128'({err_rsn, err_no_fill, err_length, err_checksum, err_timeout, words_rcvd}), 128'(0));
    check("rst_header", fill_header, 128'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_rx_tready", 128'(rx_tready), 128'(0));

    // Normal fill: length field 1 -> 12 data words, checksum 78; a start while busy is ignored.
    d0 = done_cnt; hv0 = hv_cnt;
    start_txn(32'h1234);
    @(posedge clk); #1; start = 1'b1; csn = 32'h0BAD;
    @(posedge clk); #1; start = 1'b0;
    push_hdr(32'h1234, 32'hCC00_0001);
    for (int i = 1; i <= 12; i++) begin rxq.push_back(32'(i)); exp_data.push_back(32'(i)); end
    rxq.push_back(32'd78);
    exp_res.push_back(mk_res(0, 0, 0, 0, 0, 23'd12));
    send_rx(1'b1, acc);
    check("norm_done_lat", 128'(done), 128'(1));
    @(posedge clk); #1;
    check("norm_done_pulse", 128'(done), 128'(0));
    finish_txn(d0, hv0, 1);

    // No fill response.
    d0 = done_cnt; hv0 = hv_cnt;
    start_txn(32'h1234);
    rxq = '{32'h1234, 32'hFFFF_FFF7};
    exp_res.push_back(mk_res(0, 1, 0, 0, 0, 23'd0));
    send_rx(1'b1, acc);
    finish_txn(d0, hv0, 0);

    // Bad RSN: the whole six-word packet is drained before done.
    d0 = done_cnt; hv0 = hv_cnt;
    start_txn(32'h1234);
    rxq = '{32'h1235, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    exp_res.push_back(mk_res(1, 0, 0, 0, 0, 23'd0));
    send_rx(1'b1, acc);
    check("rsn_drained", 128'(acc), 128'(6));
    check("rsn_no_early_done", 128'(done_cnt), 128'(d0));
    finish_txn(d0, hv0, 0);

    // Short packet: tlast on data word 7 of 12.
    d0 = done_cnt; hv0 = hv_cnt;
    start_txn(32'h77);
    push_hdr(32'h77, 32'h0000_0001);
    for (int i = 1; i <= 7; i++) begin rxq.push_back(32'(i * 3)); exp_data.push_back(32'(i * 3)); end
    exp_res.push_back(mk_res(0, 0, 1, 0, 0, 23'd7));
    send_rx(1'b1, acc);
    finish_txn(d0, hv0, 1);

    // Backpressure on the data path with a wrong checksum (77 instead of 78).
    d0 = done_cnt; hv0 = hv_cnt;
    start_txn(32'hA5A5_0001);
    push_hdr(32'hA5A5_0001, 32'hFFE0_0001);
    for (int i = 1; i <= 12; i++) begin rxq.push_back(32'(i)); exp_data.push_back(32'(i)); end
    rxq.push_back(32'd77);
    exp_res.push_back(mk_res(0, 0, 0, CK_EN, 0, 23'd12));
    bp_en = 1'b1;
    send_rx(1'b1, acc);
    bp_en = 1'b0;
    @(posedge clk); #2; data_tready = 1'b1;
    finish_txn(d0, hv0, 1);

    // Length field 0x1FFFFE wraps to zero data words: header goes straight to checksum.
    d0 = done_cnt; hv0 = hv_cnt;
    start_txn(32'h55);
    push_hdr(32'h55, 32'h001F_FFFE);
    rxq.push_back(32'h0);
    exp_res.push_back(mk_res(0, 0, 0, 0, 0, 23'd0));
    send_rx(1'b1, acc);
    finish_txn(d0, hv0, 1);

    // Watchdog: RX goes silent after RC; done on the 100th idle cycle.
    d0 = done_cnt; hv0 = hv_cnt;
    start_txn(32'h1234);
    rxq = '{32'h1234, 32'h8};
    exp_res.push_back(mk_res(0, 0, 0, 0, 1, 23'd0));
    send_rx(1'b0, acc);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 150);
    check("timeout_cycle", 128'(n), 128'(100));
    check("timeout_flag", 128'(err_timeout), 128'(1));
    finish_txn(d0, hv0, 0);

    // Reset in the middle of the header aborts with no done pulse.
    d0 = done_cnt;
    start_txn(32'h9);
    rxq = '{32'h9, 32'h8, 32'hDEAD_BEEF};
    send_rx(1'b0, acc);
    check("hdr_word0", 128'(fill_header[31:0]), 128'(32'hDEAD_BEEF));
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 128'({busy, done, tx_tvalid, tx_tlast, rx_tready, header_valid, data_tvalid}), 128'(0));
    check("mid_rst_status", 128'({err_rsn, err_no_fill, err_length, err_checksum, err_timeout, words_rcvd}), 128'(0));
    check("mid_rst_header", fill_header, 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_done", 128'(done_cnt), 128'(d0));
    check("mid_rst_idle", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
